// File: rtl/pic_scan_pkg.sv
// -----------------------------------------------------------------------------
// pic_scan_pkg
// Shared definitions for the picture scan controller:
//   - ROW_W / COL_W     : widths of the row address and column index
//   - DEF_ROWS/DEF_COLS : default frame geometry
//   - scan_state_t      : scan controller state encoding
// Optional feature macro used by the top: PIC_SCAN_INVERT_EN.
// -----------------------------------------------------------------------------
package pic_scan_pkg;

  localparam int ROW_W    = 9;
  localparam int COL_W    = 8;
  localparam int DEF_ROWS = 320;
  localparam int DEF_COLS = 240;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/pic_scan_ctrl_shifter.sv
// -----------------------------------------------------------------------------
// pic_row_shifter
// Holds one picture row and presents it one pixel at a time, MSB first.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture row_word, restart at column 0
//   shift_en   : advance to the next column (ignored on the last column)
//   row_word   : COLS-bit row to capture
//   msb        : current pixel (shift-register MSB)
//   col        : current column index
//   last_col   : current column is COLS-1
// COLS must be at least 2.
// -----------------------------------------------------------------------------
module pic_row_shifter
  import pic_scan_pkg::*;
#(
  parameter int COLS = DEF_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [COLS-1:0]  row_word,
  output logic             msb,
  output logic [COL_W-1:0] col,
  output logic             last_col
);

  logic [COLS-1:0]  sr_r;
  logic [COL_W-1:0] col_r;
  logic             last_r;

  // Row shift register, column counter and registered last-column flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r   <= '0;
      col_r  <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      sr_r   <= row_word;
      col_r  <= '0;
      last_r <= 1'b0;
    end else if (shift_en && !last_r) begin
      sr_r   <= {sr_r[COLS-2:0], 1'b0};
      col_r  <= col_r + COL_W'(1);
      // The flag is set as we step onto column COLS-1, so the counter
      // can never advance past it.
      last_r <= (col_r == COL_W'(COLS-2));
    end
  end

  assign msb      = sr_r[COLS-1];
  assign col      = col_r;
  assign last_col = last_r;

endmodule

// File: rtl/pic_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pic_scan_ctrl
// Scans a picture RAM row by row and streams its pixels over a valid/ready
// handshake, one pixel per accepted transfer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (aborts the frame)
//   start       : one-cycle request for a frame scan (ignored while busy)
//   row_addr    : row address to the picture RAM (holds last row after frame)
//   row_data    : combinational row word for row_addr
//   pix_valid   : pixel present on pix_data / pix_x / pix_y
//   pix_ready   : downstream accepts the pixel
//   pix_data    : pixel value (1 = white, or 1 = black when inverted)
//   pix_x/pix_y : column / row of the current pixel
//   busy        : frame scan in progress
//   frame_done  : one-cycle pulse after the last pixel was accepted
// Build option: define PIC_SCAN_INVERT_EN to output inverted pixels.
// -----------------------------------------------------------------------------
module pic_scan_ctrl
  import pic_scan_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ROW_W-1:0] row_addr,
  input  logic [COLS-1:0]  row_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic [COL_W-1:0] pix_x,
  output logic [ROW_W-1:0] pix_y,
  output logic             busy,
  output logic             frame_done
);

`ifdef PIC_SCAN_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  scan_state_t      state_r;
  logic [ROW_W-1:0] row_r;
  logic             pix_valid_r;
  logic             busy_r;
  logic             frame_done_r;

  logic             load_s;
  logic             xfer_s;
  logic             shift_en_s;
  logic             last_col_s;
  logic             msb_s;
  logic [COL_W-1:0] col_s;
  logic [COLS-1:0]  row_word_s;

  // Handshake decode and shifter controls.
  always_comb begin
    load_s     = (state_r == LOAD);
    xfer_s     = pix_valid_r & pix_ready;
    shift_en_s = xfer_s & ~last_col_s;
    // Inverting at capture time keeps pix_data a plain flop output whose
    // reset value is 0 in both build flavours.
    row_word_s = row_data ^ {COLS{INV}};
  end

  pic_row_shifter #(
    .COLS (COLS)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift_en (shift_en_s),
    .row_word (row_word_s),
    .msb      (msb_s),
    .col      (col_s),
    .last_col (last_col_s)
  );

  // Scan state machine with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      row_r        <= '0;
      pix_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pix_valid_r  <= 1'b0;
          frame_done_r <= 1'b0;
          if (start) begin
            state_r <= FETCH;
            row_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        FETCH: begin
          // row_addr is already driven from row_r; this cycle lets the RAM settle.
          state_r <= LOAD;
        end
        LOAD: begin
          state_r     <= SHIFT;
          pix_valid_r <= 1'b1;
        end
        SHIFT: begin
          if (xfer_s && last_col_s) begin
            pix_valid_r <= 1'b0;
            if (row_r == ROW_W'(ROWS-1)) begin
              state_r      <= DONE;
              frame_done_r <= 1'b1;
            end else begin
              state_r <= FETCH;
              row_r   <= row_r + ROW_W'(1);
            end
          end
        end
        DONE: begin
          // start is not looked at here, so a request in this cycle is dropped.
          state_r      <= IDLE;
          frame_done_r <= 1'b0;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          pix_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign row_addr   = row_r;
  assign pix_y      = row_r;
  assign pix_x      = col_s;
  assign pix_data   = msb_s;
  assign pix_valid  = pix_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pic_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pic_scan_ctrl
// Self-checking bench for pic_scan_ctrl with a 2-row, 240-column frame.
// A table of frame records drives each scan; expected pixels are pushed to a
// scoreboard queue before start and popped as transfers are observed.
// -----------------------------------------------------------------------------
module tb_pic_scan_ctrl;

  localparam int ROWS = 2;
  localparam int COLS = 240;

`ifdef PIC_SCAN_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic [8:0]      row_addr;
  logic [COLS-1:0] row_data;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_data;
  logic [7:0]      pix_x;
  logic [8:0]      pix_y;
  logic            busy;
  logic            frame_done;

  logic [COLS-1:0] row0_w;
  logic [COLS-1:0] row1_w;

  pic_scan_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .row_addr   (row_addr),
    .row_data   (row_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Picture RAM model: combinational row word for the addressed row.
  assign row_data = (row_addr == 9'd0) ? row0_w :
                    (row_addr == 9'd1) ? row1_w : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [COLS-1:0] row0;
    logic [COLS-1:0] row1;
    int              stall_col;
    int              stall_len;
    bit              start_mid;
    bit              start_done;
    bit              rst_mid;
    int              exp_pix;
    int              exp_done;
  } vec_t;

  typedef struct packed {
    logic [7:0] x;
    logic [8:0] y;
    logic       d;
  } pix_t;

  vec_t vecs[5];
  pix_t sb_q[$];

  int n_vec    = 0;
  int n_err    = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare, stall stability, row gap, frame_done count.
  initial begin
    bit   gap_arm = 1'b0;
    int   gap_cnt = 0;
    bit   stall_prev = 1'b0;
    pix_t sv;
    pix_t e;
    sv = '0;
    forever begin
      @(negedge clk);
      if (gap_arm) begin
        if (!pix_valid) gap_cnt++;
        else begin
          chk("row_gap_cycles", gap_cnt, 2);
          gap_arm = 1'b0;
        end
      end
      if (stall_prev && !rst) begin
        chk("stall_valid_held", int'(pix_valid), 1);
        chk("stall_x_stable", int'(pix_x), int'(sv.x));
        chk("stall_y_stable", int'(pix_y), int'(sv.y));
        chk("stall_data_stable", int'(pix_data), int'(sv.d));
      end
      stall_prev = pix_valid && !pix_ready && !rst;
      sv = '{x: pix_x, y: pix_y, d: pix_data};
      if (frame_done) done_cnt++;
      if (pix_valid) chk("busy_while_valid", int'(busy), 1);
      if (pix_valid && pix_ready && !rst) begin
        tx_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("pix_x", int'(pix_x), int'(e.x));
          chk("pix_y", int'(pix_y), int'(e.y));
          chk("pix_data", int'(pix_data), int'(e.d));
        end
        if (int'(pix_x) == COLS-1 && int'(pix_y) < ROWS-1) begin
          gap_arm = 1'b1;
          gap_cnt = 0;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_row_addr"}, int'(row_addr), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_data"}, int'(pix_data), 0);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic run_frame(input int f);
    vec_t v;
    bit   fin;
    bit   mid_started;
    int   cyc;
    int   stall_left;
    logic [COLS-1:0] w;
    v = vecs[f];
    row0_w = v.row0;
    row1_w = v.row1;
    for (int y = 0; y < ROWS; y++) begin
      w = (y == 0) ? v.row0 : v.row1;
      for (int x = 0; x < COLS; x++) begin
        sb_q.push_back('{x: 8'(x), y: 9'(y), d: w[COLS-1-x] ^ INV});
      end
    end
    tx_cnt      = 0;
    done_cnt    = 0;
    stall_left  = v.stall_len;
    fin         = 1'b0;
    mid_started = 1'b0;
    cyc         = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && cyc < 2000) begin
      if (v.rst_mid && pix_valid && pix_y == 9'd1 && pix_x == 8'd100) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        rst = 1'b0;
        chk("abort_pixels_left", sb_q.size(), 2*COLS - (COLS + 100));
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1 chk("abort_no_frame_done", done_cnt, 0);
        fin = 1'b1;
      end else if (frame_done) begin
        if (v.start_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("after_done_busy", int'(busy), 0);
        chk("after_done_frame_done", int'(frame_done), 0);
        chk("after_done_row_addr", int'(row_addr), ROWS-1);
        @(posedge clk); #1;
        chk("after_done_busy2", int'(busy), 0);
        fin = 1'b1;
      end else begin
        if (v.start_mid && !mid_started && pix_valid && pix_y == 9'd0 && pix_x == 8'd50) begin
          start       = 1'b1;
          mid_started = 1'b1;
          chk("start_mid_busy", int'(busy), 1);
        end else begin
          start = 1'b0;
        end
        if (stall_left > 0 && pix_valid && pix_y == 9'd0 && int'(pix_x) == v.stall_col) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    chk("frame_finished_in_budget", int'(fin), 1);
    chk("transfer_count", tx_cnt, v.exp_pix);
    chk("frame_done_count", done_cnt, v.exp_done);
    chk("scoreboard_empty", sb_q.size(), 0);
    if (v.stall_len > 0) chk("stall_applied", stall_left, 0);
    sb_q.delete();
  endtask

  initial begin
    vecs[0] = '{row0: {60{4'hF}},    row1: {60{4'hF}},    stall_col: -1, stall_len: 0,
                start_mid: 1'b0, start_done: 1'b0, rst_mid: 1'b0, exp_pix: 480, exp_done: 1};
    vecs[1] = '{row0: {60{4'hA}},    row1: {60{4'h5}},    stall_col: 17, stall_len: 5,
                start_mid: 1'b1, start_done: 1'b0, rst_mid: 1'b0, exp_pix: 480, exp_done: 1};
    vecs[2] = '{row0: '0,            row1: '0,            stall_col: -1, stall_len: 0,
                start_mid: 1'b0, start_done: 1'b1, rst_mid: 1'b0, exp_pix: 480, exp_done: 1};
    vecs[3] = '{row0: {30{8'h3C}},   row1: {20{12'h9E1}}, stall_col: -1, stall_len: 0,
                start_mid: 1'b0, start_done: 1'b0, rst_mid: 1'b1, exp_pix: 340, exp_done: 0};
    vecs[4] = '{row0: {24{10'h2B7}}, row1: {48{5'h13}},   stall_col: -1, stall_len: 0,
                start_mid: 1'b0, start_done: 1'b0, rst_mid: 1'b0, exp_pix: 480, exp_done: 1};

    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b1;
    row0_w    = '0;
    row1_w    = '0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    // Start held during reset must not launch a scan.
    start = 1'b1;
    @(posedge clk); #1;
    chk("reset_beats_start", int'(busy), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start_busy", int'(busy), 0);

    for (int f = 0; f < 5; f++) run_frame(f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
